// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the single-issue core.
// Optional macro SEQ_TIMEOUT_EN adds an abort-to-halt timeout on S_WAIT/S_MEM.
module pc_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_if_valid,
    output logic [WIDTH-1:0] o_if_addr,
    input  logic             i_if_ready,
    input  logic             i_if_rvalid,
    input  logic [31:0]      i_if_rdata,
    output logic [31:0]      o_inst,
    output logic             o_inst_valid,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic             i_halt,
    output logic             o_ls_valid,
    input  logic             i_ls_ready,
    input  logic             i_ls_done,
    output logic             o_pc_wen,
    output logic             o_rf_wen,
    output logic             o_halted,
    output logic [63:0]      o_instret,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_WAIT = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        acc_q, acc_d;       // LSU request already accepted
    logic        st_q, st_d;         // current instruction is a store
    logic [63:0] instret_q, instret_d;
    logic        tmo_hit;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // Zero whenever outside the wait states, so each entry starts counting afresh.
    always_ff @(posedge i_clk) begin
        if (i_rst || !(state_q == S_WAIT || state_q == S_MEM)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IF;
            inst_q    <= '0;
            acc_q     <= 1'b0;
            st_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            acc_q     <= acc_d;
            st_q      <= st_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        acc_d        = acc_q;
        st_d         = st_q;
        instret_d    = instret_q;
        o_if_valid   = 1'b0;
        o_if_addr    = '0;
        o_inst_valid = 1'b0;
        o_ls_valid   = 1'b0;
        o_pc_wen     = 1'b0;
        o_rf_wen     = 1'b0;
        o_halted     = 1'b0;
        o_timeout    = 1'b0;
        case (state_q)
            S_IF: begin
                o_if_valid = 1'b1;
                o_if_addr  = i_pc;
                // rvalid without ready is a stale response and is dropped
                if (i_if_ready) begin
                    if (i_if_rvalid) begin
                        inst_d  = i_if_rdata;
                        state_d = S_EX;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_if_rvalid) begin
                    inst_d  = i_if_rdata;
                    state_d = S_EX;
                end else if (tmo_hit) begin
                    o_timeout = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EX: begin
                o_inst_valid = 1'b1;
                st_d         = i_is_store;
                acc_d        = 1'b0;
                if (i_halt) begin
                    state_d = S_HALT;
                end else if (i_is_load || i_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                o_ls_valid = !acc_q;
                if (!acc_q && i_ls_ready) begin
                    acc_d = 1'b1;
                end
                if (i_ls_done && (acc_q || i_ls_ready)) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    o_timeout = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WB: begin
                o_pc_wen  = 1'b1;
                o_rf_wen  = !st_q;
                instret_d = instret_q + 64'd1;
                state_d   = S_IF;
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    assign o_inst    = inst_q;
    assign o_instret = instret_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized bench for pc_seq_ctrl against a per-instruction procedural reference model.
module tb_pc_seq_ctrl;
    localparam int W   = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [W-1:0]  i_pc;
    logic          o_if_valid;
    logic [W-1:0]  o_if_addr;
    logic          i_if_ready, i_if_rvalid;
    logic [31:0]   i_if_rdata;
    logic [31:0]   o_inst;
    logic          o_inst_valid;
    logic          i_is_load, i_is_store, i_halt;
    logic          o_ls_valid;
    logic          i_ls_ready, i_ls_done;
    logic          o_pc_wen, o_rf_wen, o_halted;
    logic [63:0]   o_instret;
    logic          o_timeout;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_inst;
    logic [63:0] exp_instret;
    logic        exp_halted;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pc(i_pc),
        .o_if_valid(o_if_valid), .o_if_addr(o_if_addr),
        .i_if_ready(i_if_ready), .i_if_rvalid(i_if_rvalid), .i_if_rdata(i_if_rdata),
        .o_inst(o_inst), .o_inst_valid(o_inst_valid),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_halt(i_halt),
        .o_ls_valid(o_ls_valid), .i_ls_ready(i_ls_ready), .i_ls_done(i_ls_done),
        .o_pc_wen(o_pc_wen), .o_rf_wen(o_rf_wen), .o_halted(o_halted),
        .o_instret(o_instret), .o_timeout(o_timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic ifv, input logic lsv,
                              input logic pcw, input logic rfw, input logic iv);
        check_eq({tag, ".if_valid"},   64'(o_if_valid),   64'(ifv));
        if (ifv) check_eq({tag, ".if_addr"}, 64'(o_if_addr), 64'(i_pc));
        check_eq({tag, ".ls_valid"},   64'(o_ls_valid),   64'(lsv));
        check_eq({tag, ".pc_wen"},     64'(o_pc_wen),     64'(pcw));
        check_eq({tag, ".rf_wen"},     64'(o_rf_wen),     64'(rfw));
        check_eq({tag, ".inst_valid"}, 64'(o_inst_valid), 64'(iv));
        check_eq({tag, ".inst"},       64'(o_inst),       64'(exp_inst));
        check_eq({tag, ".instret"},    o_instret,         exp_instret);
        check_eq({tag, ".halted"},     64'(o_halted),     64'(exp_halted));
        check_eq({tag, ".timeout"},    64'(o_timeout),    64'd0);
    endtask

    task automatic idle();
        i_if_ready = 1'b0; i_if_rvalid = 1'b0; i_if_rdata = '0;
        i_is_load = 1'b0; i_is_store = 1'b0; i_halt = 1'b0;
        i_ls_ready = 1'b0; i_ls_done = 1'b0;
    endtask

    // Inputs the design must ignore in the current phase get random values.
    task automatic noise();
        i_if_ready = 1'($urandom); i_if_rvalid = 1'($urandom); i_if_rdata = $urandom;
        i_is_load = 1'($urandom); i_is_store = 1'($urandom); i_halt = 1'($urandom);
        i_ls_ready = 1'($urandom); i_ls_done = 1'($urandom);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        idle();
        repeat (n) next();
        i_rst = 1'b0;
        exp_inst = '0; exp_instret = '0; exp_halted = 1'b0;
        #1 check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next();
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 halt
    task automatic run_instr(input logic [31:0] instr, input int kind, input int rdy_dly,
                             input int rv_dly, input int lrdy, input int ldone, input int halt_cyc);
        i_pc = $urandom;
        for (int c = 0; c <= rdy_dly; c++) begin
            noise();
            i_if_ready = (c == rdy_dly);
            if (c == rdy_dly) begin
                i_if_rvalid = (rv_dly == 0);
                if (rv_dly == 0) i_if_rdata = instr;
            end
            #1 check_outs("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            next();
        end
        for (int w = 1; w <= rv_dly; w++) begin
            noise();
            i_if_rvalid = (w == rv_dly);
            if (w == rv_dly) i_if_rdata = instr;
            #1 check_outs("wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            next();
        end
        exp_inst = instr;
        noise();
        i_halt = (kind == 3); i_is_load = (kind == 1); i_is_store = (kind == 2);
        #1 check_outs("ex", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next();
        if (kind == 3) begin
            exp_halted = 1'b1;
            for (int h = 0; h < halt_cyc; h++) begin
                noise();
                #1 check_outs("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                next();
            end
        end else begin
            if (kind != 0) begin
                for (int c = 0; c <= lrdy + ldone; c++) begin
                    noise();
                    i_ls_ready = (c == lrdy);
                    if (c == lrdy + ldone) i_ls_done = 1'b1;
                    else if (c >= lrdy)    i_ls_done = 1'b0;
                    #1 check_outs("mem", 1'b0, (c <= lrdy), 1'b0, 1'b0, 1'b0);
                    next();
                end
            end
            noise();
            #1 check_outs("wb", 1'b0, 1'b0, 1'b1, (kind != 2), 1'b0);
            next();
            exp_instret = exp_instret + 64'd1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_pc  = '0;
        idle();
        next();
        do_reset(3);

        run_instr(32'h00100093, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0000a103, 1, 0, 0, 2, 3, 0);
        run_instr(32'h0020a023, 2, 0, 0, 0, 0, 0);
        run_instr(32'h00100073, 3, 0, 0, 0, 0, 100);
        do_reset(3);

        for (int i = 0; i < 300; i++) begin
            int sel, kind;
            sel  = int'($urandom_range(0, 9));
            kind = (sel < 5) ? 0 : (sel < 7) ? 1 : (sel < 9) ? 2 : 3;
            run_instr($urandom, kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 10);
            if (kind == 3) do_reset(1 + int'($urandom_range(0, 2)));
        end

        // Reset while waiting on a fetch response
        idle(); i_pc = $urandom; i_if_ready = 1'b1;
        #1 check_outs("mid.fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next();
        do_reset(1);

        // Reset while an LSU access is outstanding
        idle(); i_pc = $urandom; i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_if_rdata = 32'h0000a103;
        next();
        idle(); i_is_load = 1'b1;
        next();
        idle();
        #1 check_eq("mid.ls_valid", 64'(o_ls_valid), 64'd1);
        next();
        do_reset(1);
        run_instr(32'h00100093, 0, 1, 2, 0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
        do_reset(1);
        idle(); i_pc = $urandom; i_if_ready = 1'b1;
        next();
        for (int w = 1; w <= TMO; w++) begin
            idle();
            #1 check_eq("tmo.pulse", 64'(o_timeout), 64'(w == TMO));
            check_eq("tmo.if_valid", 64'(o_if_valid), 64'd0);
            next();
        end
        idle();
        exp_halted = 1'b1;
        #1 check_outs("tmo.halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next();
        do_reset(1);
        run_instr(32'h00100093, 0, 0, 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
